// File: rtl/aes_kexp_rev.sv
// rtl/aes_kexp_rev.sv - AES key expansion emitting round keys in reverse order (NR down to 0)
// Optional build macro: AES_EQINV_EN (InvMixColumns on rounds 1..NR-1 for the equivalent inverse cipher)
module aes_kexp_rev #(
  parameter int NK = 4,
  localparam int NR = NK + 6,
  localparam int NB = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   Key  [0:4*NK-1],
  input  logic [7:0]   RCon [0:15],
  input  logic [7:0]   SBox [0:255],
  input  logic         Start,
  output logic         Busy,
  output logic         Valid,
  input  logic         Ready_in,
  output logic [127:0] RKey,
  output logic [3:0]   Round,
  output logic         Last
);

  localparam int NW = NB * (NR + 1);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_EMIT   = 2'd2;
  localparam logic [5:0] NK_W     = 6'(NK);
  localparam logic [5:0] LAST_W   = 6'(NW - 1);
  localparam logic [3:0] NR_W     = 4'(NR);
  localparam logic [2:0] PH_LAST  = 3'(NK - 1);

  logic [1:0]   state;
  logic [5:0]   idx;      // index i of the word being generated
  logic [2:0]   phase;    // i mod NK, tracked incrementally
  logic [3:0]   rc_idx;   // i / NK, tracked incrementally
  logic [3:0]   r;        // round currently presented (or next to load)
  logic         valid_q;
  logic [127:0] rkey_q;

  logic [31:0]  w [0:NW-1];
  logic [31:0]  prev, back, sub_in, sub_out, temp, new_word;
  logic [3:0]   sel_r;
  logic [5:0]   base;
  logic [127:0] emit_words;

  // Next expanded word w[i] from w[i-1] and w[i-NK]
  always_comb begin
    prev     = w[idx - 6'd1];
    back     = w[idx - NK_W];
    sub_in   = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
    sub_out  = {SBox[sub_in[31:24]], SBox[sub_in[23:16]], SBox[sub_in[15:8]], SBox[sub_in[7:0]]};
    temp     = prev;
    if (phase == 3'd0)
      temp = sub_out ^ {RCon[rc_idx], 24'h0};
    else if (NK > 6 && phase == 3'd4)
      temp = sub_out;
    new_word = back ^ temp;
  end

  // Round-key gather: first load uses r, subsequent loads step to r-1
  always_comb begin
    sel_r      = valid_q ? (r - 4'd1) : r;
    base       = {sel_r, 2'b00};
    emit_words = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
  end

  // Word store: key load on accepted Start, one new word per EXPAND cycle
  always_ff @(posedge clk) begin
    if (state == S_IDLE && Start) begin
      for (int k = 0; k < NK; k++)
        w[k] <= {Key[4*k], Key[4*k+1], Key[4*k+2], Key[4*k+3]};
    end else if (state == S_EXPAND) begin
      w[idx] <= new_word;
    end
  end

  // Control FSM: IDLE -> EXPAND -> EMIT (one load cycle, then one beat per handshake)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= 6'd0;
      phase   <= 3'd0;
      rc_idx  <= 4'd0;
      r       <= 4'd0;
      valid_q <= 1'b0;
      rkey_q  <= 128'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state  <= S_EXPAND;
            idx    <= NK_W;
            phase  <= 3'd0;
            rc_idx <= 4'd1;
          end
        end
        S_EXPAND: begin
          idx <= idx + 6'd1;
          if (phase == PH_LAST) begin
            phase  <= 3'd0;
            rc_idx <= rc_idx + 4'd1;
          end else begin
            phase <= phase + 3'd1;
          end
          if (idx == LAST_W) begin
            state <= S_EMIT;
            r     <= NR_W;
          end
        end
        S_EMIT: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
            rkey_q  <= emit_words;
          end else if (Ready_in) begin
            if (r == 4'd0) begin
              valid_q <= 1'b0;
              state   <= S_IDLE;
            end else begin
              r      <= r - 4'd1;
              rkey_q <= emit_words;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AES_EQINV_EN
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] imc_col(input logic [31:0] c);
    logic [7:0] a [0:3];
    logic [7:0] m9 [0:3], mb [0:3], md [0:3], me [0:3];
    logic [7:0] x2, x4, x8;
    for (int k = 0; k < 4; k++) begin
      a[k]  = c[31-8*k -: 8];
      x2    = xt(a[k]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Output mux: inner rounds go through InvMixColumns per column
  always_comb begin
    if (r != 4'd0 && r != NR_W)
      RKey = {imc_col(rkey_q[127:96]), imc_col(rkey_q[95:64]),
              imc_col(rkey_q[63:32]), imc_col(rkey_q[31:0])};
    else
      RKey = rkey_q;
  end
`else
  // Output mux: round keys exactly as expanded
  always_comb begin
    RKey = rkey_q;
  end
`endif

  assign Valid = valid_q;
  assign Round = r;
  assign Busy  = (state != S_IDLE);
  assign Last  = valid_q && (r == 4'd0);

endmodule

// File: tb/tb_aes_kexp_rev.sv
// tb/tb_aes_kexp_rev.sv - directed self-checking bench for aes_kexp_rev (AES-128 and AES-256)
module tb_aes_kexp_rev;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [7:0]   rcon [0:15];
  logic [7:0]   sbox [0:255];
  logic [7:0]   key128 [0:15];
  logic [7:0]   key256 [0:31];
  logic         start128, ready128, busy128, valid128, last128;
  logic         start256, ready256, busy256, valid256, last256;
  logic [127:0] rkey128, rkey256;
  logic [3:0]   round128, round256;

  int ncmp = 0;
  int nfail = 0;

  logic [127:0] exp128 [0:10];
  logic [127:0] sbox_rows [0:15];

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_JUNK = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_256  =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_kexp_rev #(.NK(4)) u128 (
    .clk(clk), .rst(rst), .Key(key128), .RCon(rcon), .SBox(sbox),
    .Start(start128), .Busy(busy128), .Valid(valid128), .Ready_in(ready128),
    .RKey(rkey128), .Round(round128), .Last(last128)
  );

  aes_kexp_rev #(.NK(8)) u256 (
    .clk(clk), .rst(rst), .Key(key256), .RCon(rcon), .SBox(sbox),
    .Start(start256), .Busy(busy256), .Valid(valid256), .Ready_in(ready256),
    .RKey(rkey256), .Round(round256), .Last(last256)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_key128(input logic [127:0] k);
    for (int i = 0; i < 16; i++) key128[i] = k[127-8*i -: 8];
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] imc128(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0] c0, c1, c2, c3;
    for (int col = 0; col < 4; col++) begin
      c0 = x[127-32*col -: 8];
      c1 = x[119-32*col -: 8];
      c2 = x[111-32*col -: 8];
      c3 = x[103-32*col -: 8];
      y[127-32*col -: 8] = gmul(c0, 8'h0e) ^ gmul(c1, 8'h0b) ^ gmul(c2, 8'h0d) ^ gmul(c3, 8'h09);
      y[119-32*col -: 8] = gmul(c0, 8'h09) ^ gmul(c1, 8'h0e) ^ gmul(c2, 8'h0b) ^ gmul(c3, 8'h0d);
      y[111-32*col -: 8] = gmul(c0, 8'h0d) ^ gmul(c1, 8'h09) ^ gmul(c2, 8'h0e) ^ gmul(c3, 8'h0b);
      y[103-32*col -: 8] = gmul(c0, 8'h0b) ^ gmul(c1, 8'h0d) ^ gmul(c2, 8'h09) ^ gmul(c3, 8'h0e);
    end
    return y;
  endfunction

  function automatic logic [127:0] want128(input int r);
`ifdef AES_EQINV_EN
    if (r != 0 && r != 10) return imc128(exp128[r]);
`endif
    return exp128[r];
  endfunction

  // mode 0: Ready_in high; mode 1: Ready_in 1,0,0 repeating; mode 2: stray Start with another key
  task automatic run128(input int mode, input string tag);
    int n, beat, cyc;
    logic [127:0] hk;
    logic [3:0] hr;
    logic held;
    set_key128(KEY_FIPS);
    start128 = 1'b1;
    tick();
    start128 = 1'b0;
    n = 0;
    while (valid128 !== 1'b1 && n < 200) begin
      if (mode == 2 && n == 10) begin set_key128(KEY_JUNK); start128 = 1'b1; end
      if (mode == 2 && n == 12) start128 = 1'b0;
      tick();
      n++;
    end
    start128 = 1'b0;
    chk({tag, " latency"}, n, 41);
    chk({tag, " busy"}, busy128, 1'b1);
    beat = 0; cyc = 0; held = 1'b0; hk = '0; hr = '0;
    while (beat < 11 && cyc < 100) begin
      ready128 = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
      if (mode == 2 && cyc == 2) begin set_key128(KEY_JUNK); start128 = 1'b1; end
      if (mode == 2 && cyc == 4) start128 = 1'b0;
      if (held) begin
        chk({tag, " hold round"}, round128, hr);
        chk({tag, " hold rkey"}, rkey128, hk);
        held = 1'b0;
      end
      chk({tag, " valid"}, valid128, 1'b1);
      if (ready128) begin
        chk({tag, " round"}, round128, 10 - beat);
        chk({tag, " rkey"}, rkey128, want128(10 - beat));
        chk({tag, " last"}, last128, (beat == 10));
        beat++;
      end else begin
        hr = round128;
        hk = rkey128;
        held = 1'b1;
      end
      tick();
      cyc++;
    end
    ready128 = 1'b1;
    start128 = 1'b0;
    chk({tag, " beats"}, beat, 11);
    if (mode != 1) chk({tag, " beat cycles"}, cyc, 11);
    chk({tag, " valid after"}, valid128, 1'b0);
    chk({tag, " busy after"}, busy128, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    start128 = 1'b0; ready128 = 1'b1;
    start256 = 1'b0; ready256 = 1'b1;
    set_key128('0);
    for (int i = 0; i < 32; i++) key256[i] = 8'h00;

    sbox_rows[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
    sbox_rows[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
    sbox_rows[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
    sbox_rows[3]  = 128'h04c723c31896059a071280e2eb27b275;
    sbox_rows[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
    sbox_rows[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
    sbox_rows[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
    sbox_rows[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
    sbox_rows[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
    sbox_rows[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
    sbox_rows[10] = 128'he0323a0a4906245cc2d3ac629195e479;
    sbox_rows[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
    sbox_rows[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
    sbox_rows[13] = 128'h703eb5664803f60e613557b986c11d9e;
    sbox_rows[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
    sbox_rows[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 16; k++)
        sbox[16*i+k] = sbox_rows[i][127-8*k -: 8];

    rcon[0]  = 8'h8d; rcon[1]  = 8'h01; rcon[2]  = 8'h02; rcon[3]  = 8'h04;
    rcon[4]  = 8'h08; rcon[5]  = 8'h10; rcon[6]  = 8'h20; rcon[7]  = 8'h40;
    rcon[8]  = 8'h80; rcon[9]  = 8'h1b; rcon[10] = 8'h36; rcon[11] = 8'h6c;
    rcon[12] = 8'hd8; rcon[13] = 8'hab; rcon[14] = 8'h4d; rcon[15] = 8'h9a;

    exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    #2;
    chk("reset busy", busy128, 1'b0);
    chk("reset valid", valid128, 1'b0);
    chk("reset last", last128, 1'b0);
    chk("reset rkey", rkey128, 128'h0);
    chk("reset round", round128, 4'd0);
    chk("reset valid256", valid256, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    run128(0, "aes128");
    tick();
    run128(1, "backpressure");
    tick();

    set_key128(KEY_FIPS);
    start128 = 1'b1;
    tick();
    start128 = 1'b0;
    repeat (20) tick();
    chk("mid-expand busy", busy128, 1'b1);
    rst = 1'b1;
    #1;
    chk("async rst busy", busy128, 1'b0);
    chk("async rst valid", valid128, 1'b0);
    chk("async rst last", last128, 1'b0);
    chk("async rst round", round128, 4'd0);
    chk("async rst rkey", rkey128, 128'h0);
    tick();
    rst = 1'b0;
    tick();
    run128(0, "after reset");
    tick();
    run128(2, "start ignored");
    tick();

    for (int i = 0; i < 32; i++) key256[i] = KEY_256[255-8*i -: 8];
    start256 = 1'b1;
    tick();
    start256 = 1'b0;
    n = 0;
    while (valid256 !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("aes256 latency", n, 53);
    chk("aes256 first round", round256, 4'd14);
    chk("aes256 first rkey", rkey256, 128'hfe4890d1e6188d0b046df344706c631e);
    repeat (14) tick();
    chk("aes256 last round", round256, 4'd0);
    chk("aes256 last rkey", rkey256, KEY_256[255:128]);
    chk("aes256 last flag", last256, 1'b1);
    tick();
    chk("aes256 valid after", valid256, 1'b0);
    chk("aes256 busy after", busy256, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
